// File: rtl/biu_axi3_rd_burst.sv
// AXI3 read-burst bus interface for cache line fills.
// Issues one WRAP burst per accepted request and forwards the returned beats to the
// cache core. Bursts still in flight when a flush arrives are drained and dropped.
module biu_axi3_rd_burst #(
    parameter int DATA_SIZE       = 32,
    parameter int ADDR_SIZE       = 32,
    parameter int BURST_BEATS     = 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter int AXI_ID          = 0
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic                 flush,
    output logic                 busy,
    output logic [3:0]           ARID,
    output logic [ADDR_SIZE-1:0] ARADDR,
    output logic [3:0]           ARLEN,
    output logic [2:0]           ARSIZE,
    output logic [1:0]           ARBURST,
    output logic                 ARVALID,
    input  logic                 AXI_ARREADY,
    input  logic [3:0]           AXI_RID,
    input  logic [DATA_SIZE-1:0] AXI_RDATA,
    input  logic [1:0]           AXI_RRESP,
    input  logic                 AXI_RLAST,
    input  logic                 AXI_RVALID,
    output logic                 RREADY,
    output logic                 rsp_valid,
    output logic [DATA_SIZE-1:0] rsp_data,
    output logic                 rsp_last,
    output logic                 rsp_err,
    input  logic                 rsp_ready
);

    localparam int BYTE_LSB = $clog2(DATA_SIZE / 8);
    localparam logic [ADDR_SIZE-1:0] ADDR_LSB_MASK = ADDR_SIZE'((64'd1 << BYTE_LSB) - 64'd1);
    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_PEND = 1'b1
    } ar_state_t;

    ar_state_t              ar_state_r;
    ar_state_t              ar_state_s;
    logic [ADDR_SIZE-1:0]   araddr_r;
    logic [3:0]             inflight_r;
    logic [3:0]             inflight_s;
    logic [3:0]             discard_r;
    logic [3:0]             discard_s;
    logic                   req_accept_s;
    logic                   r_last_hs_s;
    logic                   last_dec_s;
    logic                   unused_ok_s;

    // RID is not checked (single ID in use) and RRESP[0] only separates OKAY from EXOKAY.
    assign unused_ok_s = ^{AXI_RID, AXI_RRESP[0]};

    // Constant AR payload fields; the address is the only per-burst field.
    assign ARID    = 4'(AXI_ID);
    assign ARLEN   = 4'(BURST_BEATS - 1);
    assign ARSIZE  = 3'(BYTE_LSB);
    assign ARBURST = (BURST_BEATS > 1) ? 2'b10 : 2'b01;
    assign ARADDR  = araddr_r;
    assign ARVALID = (ar_state_r == AR_PEND);

    assign busy         = (inflight_r != 4'd0);
    assign req_accept_s = req_valid && req_ready;
    assign r_last_hs_s  = AXI_RVALID && RREADY && AXI_RLAST;
    // Guard against a stray RLAST with nothing outstanding wrapping the counter.
    assign last_dec_s   = r_last_hs_s && (inflight_r != 4'd0);

    // Beat payload passes straight through; only RRESP[1] marks SLVERR/DECERR.
    assign rsp_data = AXI_RDATA;
    assign rsp_last = AXI_RLAST;
    assign rsp_err  = AXI_RRESP[1];

    // Request acceptance: one AR at a time, bounded outstanding count, never during flush.
    always_comb begin
        if (!ARVALID && (inflight_r < MAX_OUT_C) && !flush) begin
            req_ready = 1'b1;
        end else begin
            req_ready = 1'b0;
        end
    end

    // R channel steering: drain unconditionally while discarding, else follow the core.
    always_comb begin
        if (discard_r != 4'd0) begin
            RREADY    = 1'b1;
            rsp_valid = 1'b0;
        end else begin
            RREADY    = rsp_ready;
            rsp_valid = AXI_RVALID;
        end
    end

    // AR channel next state: wait for a request, then hold until the slave takes it.
    always_comb begin
        ar_state_s = ar_state_r;
        case (ar_state_r)
            AR_IDLE: begin
                if (req_accept_s) begin
                    ar_state_s = AR_PEND;
                end else begin
                    ar_state_s = AR_IDLE;
                end
            end
            AR_PEND: begin
                if (AXI_ARREADY) begin
                    ar_state_s = AR_IDLE;
                end else begin
                    ar_state_s = AR_PEND;
                end
            end
            default: ar_state_s = AR_IDLE;
        endcase
    end

    // Outstanding-burst and discard counter updates; a flush snapshots the post-update count.
    always_comb begin
        inflight_s = inflight_r + {3'b000, req_accept_s} - {3'b000, last_dec_s};
        if (flush) begin
            discard_s = inflight_s;
        end else if ((discard_r != 4'd0) && r_last_hs_s) begin
            discard_s = discard_r - 4'd1;
        end else begin
            discard_s = discard_r;
        end
    end

    // AR state and address register; address is captured word-aligned on accept.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ar_state_r <= AR_IDLE;
            araddr_r   <= {ADDR_SIZE{1'b0}};
        end else begin
            ar_state_r <= ar_state_s;
            if (req_accept_s) begin
                araddr_r <= req_addr & ~ADDR_LSB_MASK;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            inflight_r <= 4'd0;
            discard_r  <= 4'd0;
        end else begin
            inflight_r <= inflight_s;
            discard_r  <= discard_s;
        end
    end

endmodule

// File: tb/tb_biu_axi3_rd_burst.sv
// Directed bench for biu_axi3_rd_burst with a queue-based scoreboard.
// Stimulus pushes expected AR addresses and forwarded beats; a negedge monitor
// pops and compares whenever an AR or rsp handshake is presented.
module tb_biu_axi3_rd_burst;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        busy;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        AXI_ARREADY;
    logic [3:0]  AXI_RID;
    logic [31:0] AXI_RDATA;
    logic [1:0]  AXI_RRESP;
    logic        AXI_RLAST;
    logic        AXI_RVALID;
    logic        RREADY;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic        rsp_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_ar_q[$];
    logic [33:0] exp_rsp_q[$];   // {err, last, data}
    logic [31:0] mon_ar_e;
    logic [33:0] mon_rsp_e;

    biu_axi3_rd_burst #(
        .DATA_SIZE(32), .ADDR_SIZE(32), .BURST_BEATS(8), .MAX_OUTSTANDING(2), .AXI_ID(0)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush), .busy(busy),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RID(AXI_RID), .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP),
        .AXI_RLAST(AXI_RLAST), .AXI_RVALID(AXI_RVALID), .RREADY(RREADY),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every AR and rsp handshake against the scoreboard queues.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (ARVALID && AXI_ARREADY) begin
                if (exp_ar_q.size() == 0) begin
                    check("ar_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_ar_e = exp_ar_q.pop_front();
                    check("araddr", ARADDR, mon_ar_e);
                    check("arlen", ARLEN, 4'd7);
                    check("arsize", ARSIZE, 3'd2);
                    check("arburst", ARBURST, 2'b10);
                    check("arid", ARID, 4'd0);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_rsp_e = exp_rsp_q.pop_front();
                    check("rsp_data", rsp_data, mon_rsp_e[31:0]);
                    check("rsp_last", rsp_last, mon_rsp_e[32]);
                    check("rsp_err", rsp_err, mon_rsp_e[33]);
                end
            end
        end
    end

    task automatic issue_req(input logic [31:0] addr, input logic [31:0] exp_araddr);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge ACLK);
            ok = req_ready;
            @(posedge ACLK);
            #1;
        end
        if (ok) exp_ar_q.push_back(exp_araddr);
        else check("req_accept_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic ar_accept();
        bit ok = 1'b0;
        AXI_ARREADY = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            ok = ARVALID;
            @(posedge ACLK);
            #1;
        end
        if (!ok) check("ar_handshake_timeout", 64'd0, 64'd1);
        AXI_ARREADY = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] resp,
                             input bit fwd, input bit chk_discard);
        bit hs = 1'b0;
        AXI_RVALID = 1'b1;
        AXI_RDATA  = d;
        AXI_RLAST  = last;
        AXI_RRESP  = resp;
        if (fwd) exp_rsp_q.push_back({resp[1], last, d});
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge ACLK);
            hs = RREADY;
            if (chk_discard) begin
                check("discard_rready", RREADY, 1'b1);
                check("discard_rsp_valid", rsp_valid, 1'b0);
            end
            @(posedge ACLK);
            #1;
        end
        if (!hs) check("r_handshake_timeout", 64'd0, 64'd1);
        AXI_RVALID = 1'b0;
        AXI_RLAST  = 1'b0;
        AXI_RRESP  = 2'b00;
    endtask

    task automatic send_burst(input logic [31:0] base, input int err_idx,
                              input bit fwd, input bit chk_discard);
        for (int i = 0; i < 8; i++) begin
            send_beat(base + 32'(i), (i == 7), (i == err_idx) ? 2'b10 : 2'b00, fwd, chk_discard);
        end
    endtask

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        ARESET = 1'b1; req_valid = 1'b0; req_addr = 32'd0; flush = 1'b0;
        AXI_ARREADY = 1'b0; AXI_RID = 4'd0; AXI_RDATA = 32'd0; AXI_RRESP = 2'b00;
        AXI_RLAST = 1'b0; AXI_RVALID = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;

        // Reset state
        @(negedge ACLK);
        check("reset_arvalid", ARVALID, 1'b0);
        check("reset_araddr", ARADDR, 32'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_rready", RREADY, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        @(posedge ACLK); #1;
        rsp_ready = 1'b0; flush = 1'b1; AXI_RVALID = 1'b1;
        @(negedge ACLK);
        check("reset_flush_req_ready", req_ready, 1'b0);
        check("reset_rready_follow", RREADY, 1'b0);
        check("reset_rsp_valid_follow", rsp_valid, 1'b1);
        @(posedge ACLK); #1;
        flush = 1'b0; rsp_ready = 1'b1; AXI_RVALID = 1'b0;

        // Basic line fill
        issue_req(32'h1000_0014, 32'h1000_0014);
        @(negedge ACLK);
        check("fill_arvalid", ARVALID, 1'b1);
        check("fill_busy", busy, 1'b1);
        check("fill_req_ready", req_ready, 1'b0);
        @(posedge ACLK); #1;
        ar_accept();
        send_burst(32'hA000_0000, -1, 1'b1, 1'b0);
        @(negedge ACLK);
        check("fill_busy_done", busy, 1'b0);
        @(posedge ACLK); #1;

        // AR and R backpressure
        issue_req(32'h2000_0007, 32'h2000_0004);
        req_valid = 1'b1; req_addr = 32'h2000_0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bp_arvalid", ARVALID, 1'b1);
            check("bp_araddr", ARADDR, 32'h2000_0004);
            check("bp_req_ready", req_ready, 1'b0);
        end
        @(posedge ACLK); #1;
        req_valid = 1'b0;
        ar_accept();
        rsp_ready = 1'b0;
        fork
            send_burst(32'hB000_0000, -1, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge ACLK);
                    check("bp_rready", RREADY, 1'b0);
                    check("bp_rsp_valid", rsp_valid, 1'b1);
                    check("bp_rsp_data", rsp_data, 32'hB000_0000);
                end
                @(posedge ACLK); #1;
                rsp_ready = 1'b1;
            end
        join

        // Outstanding limit
        AXI_ARREADY = 1'b1;
        issue_req(32'h3000_0000, 32'h3000_0000);
        issue_req(32'h3000_0040, 32'h3000_0040);
        req_valid = 1'b1; req_addr = 32'h3000_0080;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check("limit_req_ready_stall", req_ready, 1'b0);
        end
        @(posedge ACLK); #1;
        for (int i = 0; i < 7; i++) send_beat(32'hC000_0000 + 32'(i), 1'b0, 2'b00, 1'b1, 1'b0);
        @(negedge ACLK);
        check("limit_req_ready_before_last", req_ready, 1'b0);
        @(posedge ACLK); #1;
        send_beat(32'hC000_0007, 1'b1, 2'b00, 1'b1, 1'b0);
        @(negedge ACLK);
        check("limit_req_ready_release", req_ready, 1'b1);
        @(posedge ACLK); #1;
        exp_ar_q.push_back(32'h3000_0080);
        req_valid = 1'b0;
        send_burst(32'hC100_0000, -1, 1'b1, 1'b0);
        send_burst(32'hC200_0000, -1, 1'b1, 1'b0);
        AXI_ARREADY = 1'b0;
        @(negedge ACLK);
        check("limit_busy_done", busy, 1'b0);
        @(posedge ACLK); #1;

        // Flush with one burst partly received and one AR pending
        issue_req(32'h4000_0008, 32'h4000_0008);
        ar_accept();
        issue_req(32'h4000_0048, 32'h4000_0048);
        for (int i = 0; i < 3; i++) send_beat(32'hD000_0000 + 32'(i), 1'b0, 2'b00, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge ACLK);
        check("flush_req_ready", req_ready, 1'b0);
        check("flush_arvalid", ARVALID, 1'b1);
        @(posedge ACLK); #1;
        flush = 1'b0;
        rsp_ready = 1'b0;
        @(negedge ACLK);
        check("flush_arvalid_held", ARVALID, 1'b1);
        check("flush_araddr_held", ARADDR, 32'h4000_0048);
        check("flush_busy", busy, 1'b1);
        @(posedge ACLK); #1;
        ar_accept();
        for (int i = 3; i < 8; i++) send_beat(32'hD000_0000 + 32'(i), (i == 7), 2'b00, 1'b0, 1'b1);
        send_burst(32'hD100_0000, -1, 1'b0, 1'b1);
        @(negedge ACLK);
        check("flush_busy_done", busy, 1'b0);
        check("flush_rready_follow", RREADY, 1'b0);
        @(posedge ACLK); #1;
        rsp_ready = 1'b1;
        issue_req(32'h4000_0100, 32'h4000_0100);
        ar_accept();
        send_burst(32'hD200_0000, -1, 1'b1, 1'b0);

        // Error response on beat 4
        issue_req(32'h5000_001C, 32'h5000_001C);
        ar_accept();
        @(negedge ACLK);
        check("err_busy", busy, 1'b1);
        @(posedge ACLK); #1;
        send_burst(32'hE000_0000, 3, 1'b1, 1'b0);
        @(negedge ACLK);
        check("err_busy_done", busy, 1'b0);
        @(posedge ACLK); #1;

        // Reset mid-burst with an AR pending
        issue_req(32'h6000_0000, 32'h6000_0000);
        ar_accept();
        issue_req(32'h6000_0040, 32'h6000_0040);
        send_beat(32'hF000_0000, 1'b0, 2'b00, 1'b1, 1'b0);
        send_beat(32'hF000_0001, 1'b0, 2'b00, 1'b1, 1'b0);
        rsp_ready = 1'b0;
        AXI_RVALID = 1'b1; AXI_RDATA = 32'hF000_0002;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        exp_ar_q.delete();
        @(negedge ACLK);
        check("rst_mid_arvalid", ARVALID, 1'b0);
        check("rst_mid_araddr", ARADDR, 32'd0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_rsp_valid", rsp_valid, 1'b1);
        check("rst_mid_rready", RREADY, 1'b0);
        check("rst_mid_req_ready", req_ready, 1'b1);
        @(posedge ACLK); #1;
        AXI_RVALID = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge ACLK);

        check("sb_rsp_queue_empty", exp_rsp_q.size(), 0);
        check("sb_ar_queue_empty", exp_ar_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/biu_axi3_rd_burst.md
BIU_AXI3_RD_BURST -- requirements
Module: biu_axi3_rd_burst

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, meaning AXI data width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_SIZE, default 32, meaning AXI address width.
REQ-003 SHALL have parameter BURST_BEATS, default 8, meaning beats per line fill (power of 2, 1..16).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, meaning max in-flight bursts (1..15).
REQ-005 SHALL have parameter AXI_ID, default 0, meaning constant ARID value.
REQ-006 SHALL have ports as listed below (one clock; reset is synchronous and active-high):
 ACLK  in  1  clock, all logic on rising edge
 ARESET  in  1  synchronous active-high reset
 req_valid  in  1  line-fill request
 req_ready  out  1  request accepted this cycle when both high
 req_addr  in  ADDR_SIZE  critical-word address
 flush  in  1  discard all in-flight bursts
 busy  out  1  bursts in flight
 ARID  out  4  read ID
 ARADDR  out  ADDR_SIZE  burst address
 ARLEN  out  4  beats-1
 ARSIZE  out  3  beat size
 ARBURST  out  2  burst type
 ARVALID  out  1  AR valid
 AXI_ARREADY  in  1  AR ready
 AXI_RID  in  4  read ID (ignored)
 AXI_RDATA  in  DATA_SIZE  read data
 AXI_RRESP  in  2  read response
 AXI_RLAST  in  1  last beat
 AXI_RVALID  in  1  R valid
 RREADY  out  1  R ready
 rsp_valid  out  1  beat to cache core
 rsp_data  out  DATA_SIZE  beat data
 rsp_last  out  1  last beat of burst
 rsp_err  out  1  beat error
 rsp_ready  in  1  cache core accepts beat

Function
REQ-007 SHALL drive req_ready = !ARVALID && inflight < MAX_OUTSTANDING && !flush (combinational).
REQ-008 SHALL, on request accept, assert ARVALID next cycle with ARADDR = req_addr with low log2(DATA_SIZE/8) bits cleared, ARLEN = BURST_BEATS-1, ARSIZE = log2(DATA_SIZE/8), ARID = AXI_ID.
REQ-009 SHALL drive ARBURST = 2'b10 (WRAP) when BURST_BEATS>1, else 2'b01 (INCR).
REQ-010 SHALL hold ARVALID and all AR payload stable until AXI_ARREADY; ARVALID deasserts the cycle after handshake; flush SHALL NOT retract a pending ARVALID.
REQ-011 SHALL keep inflight counter: +1 on request accept, -1 on R handshake (AXI_RVALID && RREADY) with AXI_RLAST; both same cycle leaves it unchanged; never exceeds MAX_OUTSTANDING.
REQ-012 SHALL drive busy = (inflight != 0).
REQ-013 SHALL keep discard counter; on flush load discard <= inflight value after this cycle's update (includes partly received burst).
REQ-014 SHALL, while discard != 0, drive RREADY=1, rsp_valid=0, and decrement discard on each RLAST handshake.
REQ-015 SHALL, while discard == 0, drive RREADY = rsp_ready and rsp_valid = AXI_RVALID (combinational, zero latency).
REQ-016 SHALL drive rsp_data = AXI_RDATA, rsp_last = AXI_RLAST, rsp_err = AXI_RRESP[1] (SLVERR/DECERR); burst continues to RLAST after error.
REQ-017 SHALL accept a new request in the cycle flush deasserts if REQ-007 holds; beats of new bursts are forwarded only after discard reaches 0 (in-order, single ID).
REQ-018 SHALL treat flush asserted with discard != 0 as reload per REQ-013.

Reset
REQ-019 SHALL, on ARESET high at a clock edge, set ARVALID=0, ARADDR=0, inflight=0, discard=0; hence busy=0, RREADY=rsp_ready, rsp_valid=AXI_RVALID and req_ready=!flush after reset.
REQ-020 SHALL abandon any pending AR or R transfer on reset mid-operation (system resets interconnect together).

Verification
REQ-021 Fill: req_addr=0x1000_0014, BURST_BEATS=8, DATA_SIZE=32 -> ARADDR=0x1000_0014, ARLEN=7, ARSIZE=2, ARBURST=2'b10; 8 beats forwarded, rsp_last on 8th, busy 1->0.
REQ-022 Backpressure: AXI_ARREADY low 5 cycles -> ARVALID/ARADDR stable, req_ready=0; rsp_ready low -> RREADY low, beat held.
REQ-023 Outstanding limit: MAX_OUTSTANDING=2, three back-to-back requests -> third stalls (req_ready=0) until first RLAST handshake.
REQ-024 Flush: flush after beat 3 of burst A with burst B pending AR -> discard=2, remaining 5+8 beats consumed with RREADY=1, rsp_valid=0; next request C's beats forwarded.
REQ-025 Error: AXI_RRESP=2'b10 on beat 4 -> rsp_err=1 that beat only, burst completes, inflight decrements on RLAST.
REQ-026 Reset mid-burst: ARESET high during beat 2 -> next cycle ARVALID=0, busy=0, discard=0.
